// File: rtl/mccu_pkg.sv
// mccu_pkg: opcodes, op classes, states, ALU codes and the static decode shared by the multi-cycle CU.
package mccu_pkg;
  typedef enum logic [3:0] {
    C_NOP, C_ALU_R, C_SHIFT, C_MUL, C_ALU_I, C_LOAD, C_STORE, C_BEQ, C_BNE, C_JUMP, C_ILLEGAL
  } op_class_t;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_MULW = 3'd5
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_SRL = 4'b1100;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [5:0] OPC_R0    = 6'b000000;
  localparam logic [5:0] OPC_R1    = 6'b000001;
  localparam logic [5:0] OPC_SHIFT = 6'b000010;
  localparam logic [5:0] OPC_MUL   = 6'b000011;
  localparam logic [5:0] OPC_ADDI  = 6'b000101;
  localparam logic [5:0] OPC_ANDI  = 6'b001001;
  localparam logic [5:0] OPC_ORI   = 6'b001010;
  localparam logic [5:0] OPC_XORI  = 6'b001011;
  localparam logic [5:0] OPC_SUBI  = 6'b001100;
  localparam logic [5:0] OPC_LW    = 6'b001101;
  localparam logic [5:0] OPC_SW    = 6'b001110;
  localparam logic [5:0] OPC_BEQ   = 6'b001111;
  localparam logic [5:0] OPC_BNE   = 6'b010000;
  localparam logic [5:0] OPC_J     = 6'b010001;
  localparam logic [5:0] F_ADD = 6'd1;
  localparam logic [5:0] F_SUB = 6'd2;
  localparam logic [5:0] F_AND = 6'd3;
  localparam logic [5:0] F_OR  = 6'd4;
  localparam logic [5:0] F_XOR = 6'd5;
  localparam logic [5:0] F_SLL = 6'd1;
  localparam logic [5:0] F_SRL = 6'd2;
  localparam logic [5:0] F_SRA = 6'd3;
  localparam logic [5:0] F_MUL = 6'd1;
  typedef struct packed {
    op_class_t  cls;
    logic [3:0] aluc;
    logic       aluimm;
    logic       shift;
    logic       sext;
    logic       sst;
  } dec_t;
  function automatic dec_t decode_op(input logic [11:0] op);
    logic [5:0] opc;
    logic [5:0] fn;
    dec_t d;
    opc = op[11:6];
    fn = op[5:0];
    d = '{C_ILLEGAL, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0};
    case (opc)
      OPC_R0, OPC_R1: begin
        d.cls = (fn >= F_ADD && fn <= F_XOR) ? C_ALU_R : C_ILLEGAL;
        d.aluc = fn == F_SUB ? ALU_SUB : fn == F_AND ? ALU_AND : fn == F_OR ? ALU_OR :
                 fn == F_XOR ? ALU_XOR : ALU_ADD;
      end
      OPC_SHIFT: begin
        d.cls = (fn >= F_SLL && fn <= F_SRA) ? C_SHIFT : C_ILLEGAL;
        d.aluc = fn == F_SRL ? ALU_SRL : fn == F_SRA ? ALU_SRA : ALU_SLL;
        d.shift = 1'b1;
      end
      OPC_MUL: d.cls = fn == F_MUL ? C_MUL : C_ILLEGAL;
      OPC_ADDI: d = '{C_ALU_I, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1};
      OPC_ANDI: d = '{C_ALU_I, ALU_AND, 1'b1, 1'b0, 1'b0, 1'b1};
      OPC_ORI:  d = '{C_ALU_I, ALU_OR,  1'b1, 1'b0, 1'b0, 1'b1};
      OPC_XORI: d = '{C_ALU_I, ALU_XOR, 1'b1, 1'b0, 1'b0, 1'b1};
      OPC_SUBI: d = '{C_ALU_I, ALU_SUB, 1'b1, 1'b0, 1'b1, 1'b1};
      OPC_LW:   d = '{C_LOAD,  ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1};
      OPC_SW:   d = '{C_STORE, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0};
      OPC_BEQ:  d = '{C_BEQ,   ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0};
      OPC_BNE:  d = '{C_BNE,   ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0};
      OPC_J:    d = '{C_JUMP,  ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0};
      default: ;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/mccu_decode.sv
// mccu_decode: combinational op field -> op class and static datapath controls.
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [11:0] op,
  output dec_t        dec
);
  assign dec = decode_op(op);
endmodule

// File: rtl/mccu.sv
// mccu: multi-cycle control unit sequencing FETCH/DECODE/EXEC/MEM/MULW/WB with memory handshakes.
module mccu
  import mccu_pkg::*;
#(
  parameter int OP_W    = 12,
  parameter int ALUC_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int ST_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op,
  input  logic              z,
  input  logic              imem_rdy,
  input  logic              dmem_rdy,
  output logic              imem_req,
  output logic              dmem_req,
  output logic              pc_we,
  output logic              ir_we,
  output logic [1:0]        pcsource,
  output logic              cu_m2reg,
  output logic              cu_wmem,
  output logic              cu_shift,
  output logic              cu_aluimm,
  output logic              cu_wreg,
  output logic              cu_sext,
  output logic              cu_sst,
  output logic [ALUC_W-1:0] cu_aluc,
  output logic              mul_start,
  output logic              instret,
  output logic              illegal,
  output logic [ST_W-1:0]   state
);
  dec_t dec, dr;
  state_t st;
  logic [7:0] cnt;
  logic rst_d, act, xs, taken, is_br;
  mccu_decode u_dec (.op({op[OP_W-1 -: 6], op[5:0]}), .dec(dec));
  // The FSM idles in FETCH for the cycle after reset so every output stays low there.
  always_ff @(posedge clk) begin
    rst_d <= rst;
    if (rst) begin
      st <= S_FETCH;
      cnt <= '0;
      dr <= '{C_NOP, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    end else if (!rst_d) begin
      case (st)
        S_FETCH: if (imem_rdy) st <= S_DECODE;
        S_DECODE: begin
          dr <= dec;
          st <= dec.cls == C_ILLEGAL ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          if (dr.cls == C_MUL) cnt <= 8'(MUL_LAT - 1);
          st <= (dr.cls == C_LOAD || dr.cls == C_STORE) ? S_MEM :
                (dr.cls == C_MUL && MUL_LAT > 1) ? S_MULW :
                (dr.cls == C_BEQ || dr.cls == C_BNE || dr.cls == C_JUMP) ? S_FETCH : S_WB;
        end
        S_MEM: if (dmem_rdy) st <= dr.cls == C_STORE ? S_FETCH : S_WB;
        S_MULW: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) st <= S_WB;
        end
        S_WB: st <= S_FETCH;
        default: st <= S_FETCH;
      endcase
    end
  end
  assign act = !rst && !rst_d;
  assign xs = st == S_EXEC || st == S_MEM || st == S_MULW || st == S_WB;
  assign taken = (dr.cls == C_BEQ && z) || (dr.cls == C_BNE && !z);
  assign is_br = dr.cls == C_BEQ || dr.cls == C_BNE || dr.cls == C_JUMP;
  assign imem_req = act && st == S_FETCH;
  assign ir_we = imem_req && imem_rdy;
  assign pc_we = ir_we || (act && st == S_EXEC && (taken || dr.cls == C_JUMP));
  assign pcsource = (!act || st != S_EXEC) ? 2'b00 : dr.cls == C_JUMP ? 2'b11 : taken ? 2'b01 : 2'b00;
  assign dmem_req = act && st == S_MEM;
  assign cu_wmem = dmem_req && dr.cls == C_STORE;
  assign cu_wreg = act && st == S_WB;
  assign cu_m2reg = cu_wreg && dr.cls == C_LOAD;
  assign cu_aluc = (act && xs) ? ALUC_W'(dr.aluc) : '0;
  assign cu_aluimm = act && xs && dr.aluimm;
  assign cu_shift = act && xs && dr.shift;
  assign cu_sext = act && xs && dr.sext;
  assign cu_sst = act && xs && dr.sst;
  assign mul_start = act && st == S_EXEC && dr.cls == C_MUL;
  assign instret = act && (st == S_WB || (st == S_EXEC && is_br) ||
                           (st == S_MEM && dmem_rdy && dr.cls == C_STORE));
  assign illegal = act && st == S_DECODE && dec.cls == C_ILLEGAL;
  assign state = act ? ST_W'(st) : '0;
endmodule

// File: tb/tb_mccu.sv
// tb_mccu: directed per-cycle checks of the multi-cycle control unit outputs.
module tb_mccu;
  logic clk = 1'b0, rst = 1'b1, z = 1'b0, imem_rdy = 1'b0, dmem_rdy = 1'b0;
  logic [11:0] op = '0;
  logic imem_req, dmem_req, pc_we, ir_we, cu_m2reg, cu_wmem, cu_shift, cu_aluimm, cu_wreg;
  logic cu_sext, cu_sst, mul_start, instret, illegal;
  logic [1:0] pcsource;
  logic [3:0] cu_aluc;
  logic [2:0] state;
  logic [22:0] outs;
  int n_cmp = 0, n_bad = 0;
  // state | imem_req ir_we pc_we | pcsource | dmem_req wmem wreg m2reg | aluc | aluimm shift sext sst | mul_start instret illegal
  localparam logic [22:0] ZERO   = 23'b000_000_00_0000_0000_0000_000;
  localparam logic [22:0] F_RDY  = 23'b000_111_00_0000_0000_0000_000;
  localparam logic [22:0] F_WAIT = 23'b000_100_00_0000_0000_0000_000;
  localparam logic [22:0] DEC    = 23'b001_000_00_0000_0000_0000_000;
  localparam logic [22:0] ILL    = 23'b001_000_00_0000_0000_0000_001;
  mccu #(.OP_W(12), .ALUC_W(4), .MUL_LAT(4), .ST_W(3)) dut (
    .clk(clk), .rst(rst), .op(op), .z(z), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .imem_req(imem_req), .dmem_req(dmem_req), .pc_we(pc_we), .ir_we(ir_we), .pcsource(pcsource),
    .cu_m2reg(cu_m2reg), .cu_wmem(cu_wmem), .cu_shift(cu_shift), .cu_aluimm(cu_aluimm),
    .cu_wreg(cu_wreg), .cu_sext(cu_sext), .cu_sst(cu_sst), .cu_aluc(cu_aluc),
    .mul_start(mul_start), .instret(instret), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  assign outs = {state, imem_req, ir_we, pc_we, pcsource, dmem_req, cu_wmem, cu_wreg, cu_m2reg,
                 cu_aluc, cu_aluimm, cu_shift, cu_sext, cu_sst, mul_start, instret, illegal};
  task automatic test_reset();
    logic [22:0] ex [6];
    ex = '{ZERO, ZERO, F_RDY, DEC, 23'b010_000_00_0000_0000_0000_000, 23'b100_000_00_0010_0000_0000_010};
    op = 12'b000000_000001;
    imem_rdy = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      rst = (i == 0);
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL reset_add cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load();
    logic [22:0] ex [8];
    ex = '{F_RDY, DEC, 23'b010_000_00_0000_0000_1011_000,
           23'b011_000_00_1000_0000_1011_000, 23'b011_000_00_1000_0000_1011_000,
           23'b011_000_00_1000_0000_1011_000, 23'b011_000_00_1000_0000_1011_000,
           23'b100_000_00_0011_0000_1011_010};
    op = 12'b001101_000000;
    for (int i = 0; i < 8; i++) begin
      dmem_rdy = (i < 2 || i == 6);
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL load cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
    dmem_rdy = 1'b0;
  endtask
  task automatic test_branch();
    logic [22:0] ex [6];
    ex = '{F_RDY, DEC, 23'b010_001_01_0000_0001_0010_010, F_RDY, DEC, 23'b010_000_00_0000_0001_0010_010};
    z = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = i < 3 ? 12'b001111_000000 : 12'b010000_000000;
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL branch cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
    z = 1'b0;
  endtask
  task automatic test_jump();
    logic [22:0] ex [3];
    ex = '{F_RDY, DEC, 23'b010_001_11_0000_0000_0000_010};
    op = 12'b010001_000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL jump cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back();
    logic [22:0] ex [8];
    ex = '{F_RDY, DEC, 23'b010_000_00_0000_0100_1001_000, 23'b100_000_00_0010_0100_1001_010,
           F_RDY, DEC, 23'b010_000_00_0000_1000_0100_000, 23'b100_000_00_0010_1000_0100_010};
    for (int i = 0; i < 8; i++) begin
      op = i < 4 ? 12'b001011_000000 : 12'b000010_000011;
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL b2b cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_mul();
    logic [22:0] ex [7];
    ex = '{F_RDY, DEC, 23'b010_000_00_0000_0000_0000_100, 23'b101_000_00_0000_0000_0000_000,
           23'b101_000_00_0000_0000_0000_000, 23'b101_000_00_0000_0000_0000_000,
           23'b100_000_00_0010_0000_0000_010};
    op = 12'b000011_000001;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL mul cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_store();
    logic [22:0] ex [4];
    ex = '{F_RDY, DEC, 23'b010_000_00_0000_0000_1010_000, 23'b011_000_00_1100_0000_1010_010};
    op = 12'b001110_000000;
    for (int i = 0; i < 4; i++) begin
      dmem_rdy = (i == 3);
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL store cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
    dmem_rdy = 1'b0;
  endtask
  task automatic test_illegal();
    logic [22:0] ex [6];
    ex = '{F_RDY, ILL, F_RDY, ILL, F_WAIT, F_WAIT};
    for (int i = 0; i < 6; i++) begin
      op = i < 2 ? 12'b111111_000000 : 12'b000000_000111;
      imem_rdy = (i < 4);
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL illegal cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid_store();
    logic [22:0] ex [8];
    ex = '{F_RDY, DEC, 23'b010_000_00_0000_0000_1010_000, 23'b011_000_00_1100_0000_1010_000,
           23'b011_000_00_1100_0000_1010_000, ZERO, ZERO, F_WAIT};
    op = 12'b001110_000000;
    for (int i = 0; i < 8; i++) begin
      imem_rdy = (i != 7);
      rst = (i == 5);
      dmem_rdy = (i == 5);
      @(negedge clk);
      n_cmp++;
      if (outs !== ex[i]) begin n_bad++; $display("FAIL rst_store cyc %0d: got %b want %b", i, outs, ex[i]); end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_load();
    test_branch();
    test_jump();
    test_back_to_back();
    test_mul();
    test_store();
    test_illegal();
    imem_rdy = 1'b1;
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
